// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port register file and its clear sequencer.
package regfile_pkg;

    typedef enum logic {
        RF_CLEAR,
        RF_READY
    } rf_state_t;

    localparam int RF_ZERO_IDX = 0;

endpackage

// File: rtl/regfile_multiport_if.sv
// Decode/writeback-facing bus of the register file: read ports, write ports, scoreboard and PC.
interface regfile_multiport_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_RD     = 2
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr;
    logic [NUM_RD*DATA_WIDTH-1:0] rd_data;
    logic                         wr0_en;
    logic [ADDR_WIDTH-1:0]        wr0_addr;
    logic [DATA_WIDTH-1:0]        wr0_data;
    logic                         wr1_en;
    logic [ADDR_WIDTH-1:0]        wr1_addr;
    logic [DATA_WIDTH-1:0]        wr1_data;
    logic                         busy_set_en;
    logic [ADDR_WIDTH-1:0]        busy_set_addr;
    logic [DEPTH-1:0]             busy;
    logic                         pc_wen;
    logic [DATA_WIDTH-1:0]        pc_in;
    logic [DATA_WIDTH-1:0]        pc;
    logic                         init_done;

    modport master (
        output rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
               busy_set_en, busy_set_addr, pc_wen, pc_in,
        input  rd_data, busy, pc, init_done
    );

    modport slave (
        input  rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
               busy_set_en, busy_set_addr, pc_wen, pc_in,
        output rd_data, busy, pc, init_done
    );

endinterface

// File: rtl/regfile_init_seq.sv
// Post-reset clear sequencer: walks every register index once, then holds READY until the next reset.
module regfile_init_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  clr_en,
    output logic [ADDR_WIDTH-1:0] clr_addr,
    output logic                  init_done
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;

    rf_state_t             state_q;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic                  done_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RF_CLEAR;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                RF_CLEAR: begin
                    cnt_q <= cnt_q + ADDR_WIDTH'(1);
                    if (cnt_q == LAST_IDX) begin
                        state_q <= RF_READY;
                        done_q  <= 1'b1;
                    end
                end
                RF_READY: begin
                    done_q <= 1'b1;
                end
            endcase
        end
    end

    assign clr_en    = (state_q == RF_CLEAR);
    assign clr_addr  = cnt_q;
    assign init_done = done_q;

endmodule

// File: rtl/regfile_multiport.sv
// Architectural register file with NUM_RD bypassed read ports, two prioritised write ports,
// a per-register busy scoreboard and the PC; storage is zeroed by the clear sequencer after reset.
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 5,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_RD     = 2,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h3000_0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_multiport_if.slave   bus
);

    localparam int                    DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(RF_ZERO_IDX);

    logic                  clr_en;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  init_done;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]      busy_q;
    logic [DEPTH-1:0]      busy_d;
    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] pc_d;

    logic wr0_hit;
    logic wr1_hit;

    regfile_init_seq #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_init_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_en    (clr_en),
        .clr_addr  (clr_addr),
        .init_done (init_done)
    );

    assign wr0_hit = init_done && bus.wr0_en && (bus.wr0_addr != ZERO_ADDR);
    assign wr1_hit = init_done && bus.wr1_en && (bus.wr1_addr != ZERO_ADDR);

    // wr1 is applied after wr0 so it wins a same-address collision.
    always_comb begin
        mem_d = mem_q;
        if (clr_en) begin
            mem_d[clr_addr] = '0;
        end else begin
            if (wr0_hit) mem_d[bus.wr0_addr] = bus.wr0_data;
            if (wr1_hit) mem_d[bus.wr1_addr] = bus.wr1_data;
        end
    end

    // Storage carries no reset; the clear sequencer zeroes it instead.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Set is applied last so a new producer outranks a completing writeback.
    always_comb begin
        busy_d = busy_q;
        if (init_done) begin
            if (bus.wr0_en)      busy_d[bus.wr0_addr]      = 1'b0;
            if (bus.wr1_en)      busy_d[bus.wr1_addr]      = 1'b0;
            if (bus.busy_set_en) busy_d[bus.busy_set_addr] = 1'b1;
        end
        busy_d[RF_ZERO_IDX] = 1'b0;
    end

    always_comb begin
        pc_d = pc_q;
        if (init_done && bus.pc_wen) pc_d = bus.pc_in;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= '0;
            pc_q   <= RESET_PC;
        end else begin
            busy_q <= busy_d;
            pc_q   <= pc_d;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic [DATA_WIDTH-1:0] rdata;

        assign ra = bus.rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            rdata = mem_q[ra];
            if (!init_done || ra == ZERO_ADDR) begin
                rdata = '0;
            end else if (bus.wr1_en && bus.wr1_addr == ra) begin
                rdata = bus.wr1_data;
            end else if (bus.wr0_en && bus.wr0_addr == ra) begin
                rdata = bus.wr0_data;
            end
        end

        assign bus.rd_data[i*DATA_WIDTH +: DATA_WIDTH] = rdata;
    end

    assign bus.busy      = busy_q;
    assign bus.pc        = pc_q;
    assign bus.init_done = init_done;

endmodule
